multi_alarm_clock: RTL and testbench

Parametrised successor of the lab digital clock: a 24 h / 12 h time-of-day counter with an in-place set mode, blinking field indication and N independent programmable alarms with acknowledge and auto-timeout. Sits between the debounced button/switch front end and the 8-digit seven-segment scanner, which consumes `out` as eight 4-bit digit codes.

---
 rtl/clock_pkg.sv | 16 +
 rtl/bcd_split.sv | 13 +
 rtl/multi_alarm_clock.sv | 182 ++++++++++++++++++
 tb/tb_multi_alarm_clock.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the multi-alarm time-of-day clock.
package clock_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_SET_MIN,
    S_SET_HR
  } state_t;

  localparam logic [3:0] DIG_SEP   = 4'hE;
  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [4:0] HR_MAX    = 5'd23;

endpackage

// File: rtl/bcd_split.sv
// Splits a 0..59 binary value into tens and ones BCD digits.
module bcd_split (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  always_comb begin
    tens = 4'(bin / 6'd10);
    ones = 4'(bin % 6'd10);
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24 h / 12 h time-of-day clock with in-place set mode, blinking field
// indication and N programmable alarms with acknowledge and auto-timeout.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int BLINK_HALF = 300,
  parameter int N_ALARMS   = 4,
  parameter int RING_SECS  = 60
) (
  input  logic                clk_1khz,
  input  logic                rst,
  input  logic                set_en,
  input  logic                switch,
  input  logic                add,
  input  logic                mode_12h,
  input  logic                alarm_wr,
  input  logic [3:0]          alarm_idx,
  input  logic [4:0]          alarm_hr,
  input  logic [5:0]          alarm_min,
  input  logic                alarm_on,
  input  logic                ack,
  output logic [31:0]         out,
  output logic                pm,
  output logic                sec_pulse,
  output logic                alarm_ringing,
  output logic [N_ALARMS-1:0] alarm_hit
);

  localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_HALF > 0) ? $clog2(2 * BLINK_HALF) : 1;
  localparam int RW = (RING_SECS > 0) ? $clog2(RING_SECS + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX   = TW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_OFF  = BW'(BLINK_HALF);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_SECS - 1);

  logic          sw_d, add_d, ack_d;
  logic          sw_edge, add_edge, ack_edge;
  state_t        state, state_nxt;
  logic [TW-1:0] tick;
  logic [BW-1:0] blink;
  logic [5:0]    sec, min, min_inc;
  logic [4:0]    hr, hr_inc, hr_new, hr_disp;
  logic          sec_wrap, min_roll, hr_roll;

  logic [N_ALARMS-1:0] al_on;
  logic [4:0]          al_hr  [N_ALARMS];
  logic [5:0]          al_min [N_ALARMS];
  logic [N_ALARMS-1:0] hit_vec;
  logic [RW-1:0]       ring_cnt;
  logic                timeout, ring_clear, wr_ok;

  assign sw_edge  = switch & ~sw_d;
  assign add_edge = add & ~add_d;
  assign ack_edge = ack & ~ack_d;

  assign sec_wrap = !set_en && (tick == TICK_MAX);
  assign min_roll = sec_wrap && (sec == SEC_MAX);
  assign hr_roll  = min_roll && (min == MIN_MAX);
  assign min_inc  = (min == MIN_MAX) ? 6'd0 : min + 6'd1;
  assign hr_inc   = (hr == HR_MAX) ? 5'd0 : hr + 5'd1;
  assign hr_new   = hr_roll ? hr_inc : hr;

  always_comb begin
    state_nxt = state;
    if (!set_en) begin
      state_nxt = S_RUN;
    end else if (sw_edge) begin
      case (state)
        S_RUN:     state_nxt = S_SET_MIN;
        S_SET_MIN: state_nxt = S_SET_HR;
        default:   state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      sw_d      <= 1'b0;
      add_d     <= 1'b0;
      ack_d     <= 1'b0;
      state     <= S_RUN;
      blink     <= '0;
      tick      <= '0;
      sec       <= '0;
      min       <= '0;
      hr        <= '0;
      sec_pulse <= 1'b0;
    end else begin
      sw_d      <= switch;
      add_d     <= add;
      ack_d     <= ack;
      state     <= state_nxt;
      blink     <= (state_nxt != state || blink == BLINK_LAST) ? '0 : blink + 1'b1;
      sec_pulse <= sec_wrap;
      if (!set_en) begin
        tick <= sec_wrap ? '0 : tick + 1'b1;
        if (sec_wrap) sec <= (sec == SEC_MAX) ? 6'd0 : sec + 6'd1;
        if (min_roll) min <= min_inc;
        if (hr_roll) hr <= hr_inc;
      end else begin
        // Set mode freezes time; adjusting a field restarts the minute cleanly.
        tick <= '0;
        if (add_edge && state == S_SET_MIN) begin
          min <= min_inc;
          sec <= '0;
        end else if (add_edge && state == S_SET_HR) begin
          hr  <= hr_inc;
          sec <= '0;
        end
      end
    end
  end

  assign wr_ok = alarm_wr && (alarm_hr <= HR_MAX) && (alarm_min <= MIN_MAX);

  always_ff @(posedge clk_1khz) begin
    for (int i = 0; i < N_ALARMS; i++) begin
      if (rst) begin
        al_on[i]  <= 1'b0;
        al_hr[i]  <= '0;
        al_min[i] <= '0;
      end else if (wr_ok && alarm_idx == 4'(i)) begin
        al_on[i]  <= alarm_on;
        al_hr[i]  <= alarm_hr;
        al_min[i] <= alarm_min;
      end
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (min_roll && al_on[i] && al_hr[i] == hr_new && al_min[i] == min_inc)
        hit_vec[i] = 1'b1;
    end
  end

  assign timeout    = (RING_SECS != 0) && alarm_ringing && sec_wrap && (ring_cnt == RING_LAST);
  assign ring_clear = ack_edge || timeout;

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      alarm_ringing <= 1'b0;
      alarm_hit     <= '0;
      ring_cnt      <= '0;
    end else if (|hit_vec) begin
      // A fresh hit outranks a simultaneous acknowledge or timeout.
      alarm_ringing <= 1'b1;
      alarm_hit     <= (ring_clear ? '0 : alarm_hit) | hit_vec;
      ring_cnt      <= '0;
    end else if (ring_clear) begin
      alarm_ringing <= 1'b0;
      alarm_hit     <= '0;
      ring_cnt      <= '0;
    end else if (alarm_ringing && sec_wrap) begin
      ring_cnt <= ring_cnt + 1'b1;
    end
  end

  always_comb begin
    hr_disp = hr;
    if (mode_12h && hr == 5'd0) hr_disp = 5'd12;
    else if (mode_12h && hr > 5'd12) hr_disp = hr - 5'd12;
  end

  logic [3:0] h10, h1, m10, m1, s10, s1;
  logic       blank_hr, blank_min;

  bcd_split u_bcd_hr  (.bin({1'b0, hr_disp}), .tens(h10), .ones(h1));
  bcd_split u_bcd_min (.bin(min),              .tens(m10), .ones(m1));
  bcd_split u_bcd_sec (.bin(sec),              .tens(s10), .ones(s1));

  assign blank_hr  = (state == S_SET_HR) && (blink >= BLINK_OFF);
  assign blank_min = (state == S_SET_MIN) && (blink >= BLINK_OFF);
  assign pm        = (hr >= 5'd12);
  assign out = {blank_hr  ? {DIG_BLANK, DIG_BLANK} : {h10, h1}, DIG_SEP,
                blank_min ? {DIG_BLANK, DIG_BLANK} : {m10, m1}, DIG_SEP,
                s10, s1};

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with a queue-based scoreboard.
module tb_multi_alarm_clock;

  logic        clk_1khz = 1'b0;
  logic        rst = 1'b1;
  logic        set_en = 1'b0, switch = 1'b0, add = 1'b0, mode_12h = 1'b0;
  logic        alarm_wr = 1'b0, alarm_on = 1'b0, ack = 1'b0;
  logic [3:0]  alarm_idx = '0;
  logic [4:0]  alarm_hr = '0;
  logic [5:0]  alarm_min = '0;
  logic [31:0] out;
  logic        pm, sec_pulse, alarm_ringing;
  logic [3:0]  alarm_hit;

  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk_1khz = ~clk_1khz;

  multi_alarm_clock #(
    .CLK_HZ(10), .BLINK_HALF(5), .N_ALARMS(4), .RING_SECS(3)
  ) dut (
    .clk_1khz(clk_1khz), .rst(rst), .set_en(set_en), .switch(switch), .add(add),
    .mode_12h(mode_12h), .alarm_wr(alarm_wr), .alarm_idx(alarm_idx),
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_on(alarm_on), .ack(ack),
    .out(out), .pm(pm), .sec_pulse(sec_pulse), .alarm_ringing(alarm_ringing),
    .alarm_hit(alarm_hit)
  );

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(e);
    check(tag, obs);
  endtask

  task automatic pulse_switch();
    @(negedge clk_1khz) switch = 1'b1;
    @(negedge clk_1khz) switch = 1'b0;
  endtask

  task automatic pulse_add();
    @(negedge clk_1khz) add = 1'b1;
    @(negedge clk_1khz) add = 1'b0;
  endtask

  // One add per 10 cycles keeps the blink phase fixed at a visible point.
  task automatic add_step(input string tag, input logic [31:0] e);
    @(negedge clk_1khz) add = 1'b1;
    @(negedge clk_1khz) add = 1'b0;
    chk(tag, out, e);
    repeat (8) @(negedge clk_1khz);
  endtask

  task automatic do_reset(input logic keep_set);
    @(negedge clk_1khz);
    rst = 1'b1; set_en = keep_set; switch = 1'b0; add = 1'b0; ack = 1'b0; mode_12h = 1'b0;
    repeat (2) @(negedge clk_1khz);
    rst = 1'b0;
  endtask

  // Presets time from 00:00:00 while in set mode, ending in S_RUN.
  task automatic set_time(input int h, input int m);
    pulse_switch();
    repeat (m) pulse_add();
    pulse_switch();
    repeat (h) pulse_add();
    pulse_switch();
  endtask

  task automatic write_slot(input logic [3:0] idx, input logic [4:0] h,
                            input logic [5:0] m, input logic on);
    @(negedge clk_1khz);
    alarm_wr = 1'b1; alarm_idx = idx; alarm_hr = h; alarm_min = m; alarm_on = on;
    @(negedge clk_1khz);
    alarm_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_1khz);
    chk("rst_out", out, 32'h00E00E00);
    chk("rst_pm", pm, 0);
    chk("rst_sec_pulse", sec_pulse, 0);
    chk("rst_ringing", alarm_ringing, 0);
    chk("rst_hit", alarm_hit, 0);
    mode_12h = 1'b1; #1;
    chk("rst_out_12h", out, 32'h12E00E00);
    mode_12h = 1'b0;
    rst = 1'b0;

    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_1khz);
      chk("sec_pulse_period", sec_pulse, (k % 10 == 0) ? 1 : 0);
    end
    chk("run_3s", out, 32'h00E00E03);

    set_en = 1'b1;
    pulse_switch();
    repeat (58) pulse_add();
    pulse_switch();
    chk("set_min58_sec_clr", out, 32'h00E58E00);
    pulse_switch();
    pulse_switch();
    chk("blink_vis_start", out, 32'h00E58E00);
    repeat (4) @(negedge clk_1khz);
    chk("blink_vis_last", out, 32'h00E58E00);
    @(negedge clk_1khz);
    chk("blink_off_first", out, 32'h00EFFE00);
    repeat (4) @(negedge clk_1khz);
    chk("blink_off_last", out, 32'h00EFFE00);
    @(negedge clk_1khz);
    chk("blink_vis_again", out, 32'h00E58E00);
    add_step("add_min59", 32'h00E59E00);
    add_step("add_min_wrap", 32'h00E00E00);
    add_step("add_min01", 32'h00E01E00);

    do_reset(1'b1);
    set_time(23, 59);
    chk("preset_2359", out, 32'h23E59E00);
    set_en = 1'b0;
    repeat (500) @(negedge clk_1khz);
    chk("run_235950", out, 32'h23E59E50);
    repeat (90) @(negedge clk_1khz);
    chk("run_235959", out, 32'h23E59E59);
    repeat (10) @(negedge clk_1khz);
    chk("day_wrap", out, 32'h00E00E00);
    chk("day_wrap_pulse", sec_pulse, 1);
    mode_12h = 1'b1; #1;
    chk("h12_midnight", out, 32'h12E00E00);
    chk("h12_midnight_pm", pm, 0);
    mode_12h = 1'b0;

    set_en = 1'b1;
    pulse_switch();
    pulse_switch();
    repeat (13) pulse_add();
    pulse_switch();
    chk("h24_13", out, 32'h13E00E00);
    chk("h24_13_pm", pm, 1);
    mode_12h = 1'b1; #1;
    chk("h12_13", out, 32'h01E00E00);
    chk("h12_13_pm", pm, 1);
    pulse_switch();
    pulse_switch();
    repeat (23) pulse_add();
    pulse_switch();
    chk("h12_noon", out, 32'h12E00E00);
    chk("h12_noon_pm", pm, 1);
    pulse_add();
    chk("add_in_run_ignored", out, 32'h12E00E00);
    mode_12h = 1'b0;

    do_reset(1'b1);
    set_time(7, 29);
    write_slot(4'd2, 5'd7, 6'd30, 1'b1);
    write_slot(4'd0, 5'd7, 6'd31, 1'b1);
    write_slot(4'd1, 5'd7, 6'd32, 1'b1);
    write_slot(4'd3, 5'd7, 6'd33, 1'b1);
    write_slot(4'd3, 5'd24, 6'd33, 1'b0);
    write_slot(4'd5, 5'd7, 6'd34, 1'b1);
    write_slot(4'd0, 5'd7, 6'd60, 1'b1);
    set_en = 1'b0;
    repeat (599) @(negedge clk_1khz);
    chk("pre_alarm_quiet", alarm_ringing, 0);
    @(negedge clk_1khz);
    chk("slot2_ringing", alarm_ringing, 1);
    chk("slot2_hit", alarm_hit, 4'b0100);
    chk("slot2_time", out, 32'h07E30E00);
    chk("slot2_pulse", sec_pulse, 1);
    ack = 1'b1;
    @(negedge clk_1khz);
    ack = 1'b0;
    chk("ack_ringing", alarm_ringing, 0);
    chk("ack_hit", alarm_hit, 0);

    repeat (598) @(negedge clk_1khz);
    chk("pre_slot0_quiet", alarm_ringing, 0);
    @(negedge clk_1khz);
    chk("slot0_ringing", alarm_ringing, 1);
    chk("slot0_hit", alarm_hit, 4'b0001);
    repeat (29) @(negedge clk_1khz);
    chk("timeout_not_yet", alarm_ringing, 1);
    @(negedge clk_1khz);
    chk("timeout_ringing", alarm_ringing, 0);
    chk("timeout_hit", alarm_hit, 0);

    repeat (569) @(negedge clk_1khz);
    ack = 1'b1;
    @(negedge clk_1khz);
    ack = 1'b0;
    chk("hit_beats_ack", alarm_ringing, 1);
    chk("hit_beats_ack_bits", alarm_hit, 4'b0010);

    repeat (600) @(negedge clk_1khz);
    chk("slot3_kept_ringing", alarm_ringing, 1);
    chk("slot3_kept_hit", alarm_hit, 4'b1000);
    repeat (600) @(negedge clk_1khz);
    chk("idx5_dropped", alarm_ringing, 0);
    chk("idx5_time", out, 32'h07E34E00);

    @(negedge clk_1khz);
    rst = 1'b1; set_en = 1'b0;
    alarm_wr = 1'b1; alarm_idx = 4'd3; alarm_hr = 5'd0; alarm_min = 6'd1; alarm_on = 1'b1;
    @(negedge clk_1khz);
    rst = 1'b0; alarm_wr = 1'b0;
    repeat (600) @(negedge clk_1khz);
    chk("rst_wr_time", out, 32'h00E01E00);
    chk("rst_wr_dropped", alarm_ringing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
